esdi_cmd_sequencer: RTL and testbench
=====================================

ESDI_CMD_SEQUENCER -- requirements
Module: esdi_cmd_sequencer

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of synchroniser flops on esdi_transfer_req, esdi_command_data and esdi_drive_selected.
REQ-002 Parameter TIMEOUT_CYCLES, default 1000000: maximum aclk cycles waiting for a host req edge mid-transfer; 24-bit counter.
REQ-003 aclk  in  1  sole clock; all logic on its rising edge.
REQ-004 aresetn  in  1  asynchronous, active-low reset.
REQ-005 esdi_transfer_req  in  1  host transfer request, active-high (polarity already corrected upstream), asynchronous.
REQ-006 esdi_command_data  in  1  host serial command bit, active-high, asynchronous.
REQ-007 esdi_drive_selected  in  1  this drive selected, asynchronous.
REQ-008 esdi_transfer_ack  out  1  drive acknowledge, registered.
REQ-009 esdi_confstat_data  out  1  serial status bit to host, registered.
REQ-010 esdi_command_complete  out  1  high when no command is in progress.
REQ-011 esdi_attention  out  1  sticky attention flag.
REQ-012 cmd_valid / cmd_word[15:0] / cmd_ready  out / out / in: received-command valid/ready handshake toward the processor.
REQ-013 rsp_valid / rsp_word[15:0] / rsp_ready  in / in / out: status word handshake from the processor.
REQ-014 attn_set, attn_clr  in  1 each: processor pulses to set or clear esdi_attention.
REQ-015 parity_err, timeout_err  out  1 each: single-cycle error pulses.

Function
REQ-016 Handshake logic SHALL use only the synchronised copies (req_s, data_s, sel_s) of the asynchronous inputs.
REQ-017 FSM states SHALL be IDLE, CMD_ACK, CMD_WAIT, EXEC, RSP_WAIT, STS_WAIT, STS_SETUP, STS_ACK.
REQ-018 In IDLE, req_s high with sel_s high SHALL shift data_s into a 17-bit shift register (MSB first), set ack=1 in the next cycle, and enter CMD_ACK.
REQ-019 In CMD_ACK, req_s low SHALL clear ack and increment the 5-bit bit counter; if the count reaches 17, the FSM SHALL perform the parity check, otherwise enter CMD_WAIT.
REQ-020 In CMD_WAIT, req_s high SHALL sample the next bit, set ack, and enter CMD_ACK.
REQ-021 Parity SHALL be odd over all 17 bits (XOR of the 17 bits = 1).
REQ-022 On parity pass: cmd_word = bits[16:1], cmd_valid = 1, command_complete = 0, enter EXEC.
REQ-023 On parity fail: one-cycle parity_err pulse, attention set, no cmd_valid, command_complete stays 1, counter cleared, return to IDLE.
REQ-024 In EXEC, cmd_valid SHALL hold with cmd_word stable until cmd_ready; acceptance SHALL drop cmd_valid and enter RSP_WAIT.
REQ-025 In RSP_WAIT, rsp_ready SHALL be 1; rsp_valid SHALL latch {rsp_word, odd-parity bit} into the transmit shifter and enter STS_WAIT.
REQ-026 In STS_WAIT, req_s high SHALL drive the current bit (MSB first) on confstat_data and enter STS_SETUP; ack SHALL rise the following cycle, giving one cycle of data setup before ack.
REQ-027 In STS_ACK, req_s low SHALL clear ack; after the 17th bit the FSM SHALL set command_complete = 1, set confstat_data = 0, and enter IDLE; otherwise it SHALL return to STS_WAIT.
REQ-028 Command-bit latency SHALL be SYNC_STAGES+1 cycles from the req rise to the ack rise; ack fall SHALL occur SYNC_STAGES+1 cycles after the req fall.
REQ-029 Timeout: in CMD_ACK, CMD_WAIT, STS_WAIT or STS_ACK, TIMEOUT_CYCLES cycles without a req_s transition SHALL abort to IDLE with ack=0, command_complete=1, a timeout_err pulse, and attention set; EXEC and RSP_WAIT SHALL never time out.
REQ-030 sel_s falling mid-transfer SHALL abort to IDLE as in REQ-029, but without timeout_err and without setting attention.
REQ-031 Attention: set has priority over clear when attn_set/error and attn_clr occur in the same cycle.
REQ-032 A req_s rise in EXEC or RSP_WAIT SHALL be ignored (no ack).

Reset
REQ-033 While aresetn is low: state IDLE, ack=0, confstat_data=0, command_complete=1, attention=0, cmd_valid=0, cmd_word=0, rsp_ready=0, error pulses 0, all counters and shifters 0, synchronisers 0.
REQ-034 Reset assertion mid-transfer SHALL discard the partial word; no cmd_valid SHALL result.

Verification
REQ-035 Host sends 0x1234 with parity bit 0 -> cmd_valid with cmd_word=0x1234; command_complete=0; each ack rises exactly 3 cycles after its req.
REQ-036 Host sends 0x1234 with parity bit 1 -> parity_err pulses once, attention=1, no cmd_valid, command_complete=1.
REQ-037 After 0x1234 accepted, processor returns rsp_word=0xA5A5 -> host reads 1010010110100101 then parity bit 1; command_complete=1 after the 17th ack falls.
REQ-038 Host stops after 5 bits, TIMEOUT_CYCLES=100 -> timeout_err at cycle 100 after the last req edge, ack=0, state IDLE; a following full 0x1234 command is accepted.
REQ-039 Drive deselected during status bit 8 -> abort to IDLE, attention unchanged; req while deselected gets no ack.
REQ-040 aresetn pulsed low during command bit 10 -> all outputs at reset values; no cmd_valid emitted.

Source files
------------

// File: rtl/esdi_cmd_sequencer_if.sv
// Processor-side command/status handshake bundle
// for the ESDI command sequencer.
interface esdi_cmd_sequencer_if;
  logic        cmd_valid;
  logic [15:0] cmd_word;
  logic        cmd_ready;
  logic        rsp_valid;
  logic [15:0] rsp_word;
  logic        rsp_ready;

  modport master (
    output cmd_valid, cmd_word, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_word
  );

  modport slave (
    input  cmd_valid, cmd_word, rsp_ready,
    output cmd_ready, rsp_valid, rsp_word
  );
endinterface

// File: rtl/esdi_cmd_sequencer.sv
// ESDI serial command receiver / status transmitter
// with odd parity, timeout and attention handling.
module esdi_cmd_sequencer #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic esdi_transfer_req,
  input  logic esdi_command_data,
  input  logic esdi_drive_selected,
  output logic esdi_transfer_ack,
  output logic esdi_confstat_data,
  output logic esdi_command_complete,
  output logic esdi_attention,
  esdi_cmd_sequencer_if.master proc,
  input  logic attn_set,
  input  logic attn_clr,
  output logic parity_err,
  output logic timeout_err
);

  typedef enum logic [2:0] {
    IDLE, CMD_ACK, CMD_WAIT, EXEC,
    RSP_WAIT, STS_WAIT, STS_SETUP, STS_ACK
  } state_t;

  localparam logic [23:0] TMO_LAST =
    24'(TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] req_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic [SYNC_STAGES-1:0] sel_sync;
  logic        req_s, data_s, sel_s;
  logic        req_q, req_edge;
  state_t      state_q, state_d;
  logic        ack_q, ack_d;
  logic        sts_q, sts_d;
  logic        done_q, done_d;
  logic        attn_q, attn_d;
  logic        vld_q, vld_d;
  logic        perr_q, perr_d;
  logic        terr_q, terr_d;
  logic [15:0] word_q, word_d;
  logic [16:0] rx_q, rx_d;
  logic [16:0] tx_q, tx_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [23:0] tmo_q, tmo_d;
  logic        timed, xfer, abort, attn_hit;

  assign req_s    = req_sync[SYNC_STAGES-1];
  assign data_s   = data_sync[SYNC_STAGES-1];
  assign sel_s    = sel_sync[SYNC_STAGES-1];
  assign req_edge = req_s ^ req_q;

  assign timed = (state_q == CMD_ACK)
              || (state_q == CMD_WAIT)
              || (state_q == STS_WAIT)
              || (state_q == STS_ACK);
  assign xfer  = timed || (state_q == STS_SETUP);

  always_comb begin
    state_d  = state_q;
    ack_d    = ack_q;
    sts_d    = sts_q;
    done_d   = done_q;
    vld_d    = vld_q;
    word_d   = word_q;
    rx_d     = rx_q;
    tx_d     = tx_q;
    cnt_d    = cnt_q;
    perr_d   = 1'b0;
    terr_d   = 1'b0;
    attn_hit = 1'b0;
    abort    = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req_s && sel_s) begin
          rx_d    = {rx_q[15:0], data_s};
          ack_d   = 1'b1;
          state_d = CMD_ACK;
        end
      end
      CMD_ACK: if (!req_s) begin
        ack_d = 1'b0;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd16) begin
          cnt_d = '0;
          if (^rx_q) begin
            word_d  = rx_q[16:1];
            vld_d   = 1'b1;
            done_d  = 1'b0;
            state_d = EXEC;
          end else begin
            perr_d   = 1'b1;
            attn_hit = 1'b1;
            state_d  = IDLE;
          end
        end else begin
          state_d = CMD_WAIT;
        end
      end
      CMD_WAIT: if (req_s) begin
        rx_d    = {rx_q[15:0], data_s};
        ack_d   = 1'b1;
        state_d = CMD_ACK;
      end
      EXEC: if (proc.cmd_ready) begin
        vld_d   = 1'b0;
        state_d = RSP_WAIT;
      end
      RSP_WAIT: if (proc.rsp_valid) begin
        tx_d    = {proc.rsp_word, ~^proc.rsp_word};
        cnt_d   = '0;
        state_d = STS_WAIT;
      end
      STS_WAIT: if (req_s) begin
        sts_d   = tx_q[16];
        tx_d    = {tx_q[15:0], 1'b0};
        state_d = STS_SETUP;
      end
      // data has been on the line one cycle; ack now
      STS_SETUP: begin
        ack_d   = 1'b1;
        state_d = STS_ACK;
      end
      STS_ACK: if (!req_s) begin
        ack_d = 1'b0;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd16) begin
          cnt_d   = '0;
          done_d  = 1'b1;
          sts_d   = 1'b0;
          state_d = IDLE;
        end else begin
          state_d = STS_WAIT;
        end
      end
      default: state_d = IDLE;
    endcase

    if (xfer && !sel_s) begin
      abort = 1'b1;
    end else if (timed && !req_edge
                 && tmo_q == TMO_LAST) begin
      abort    = 1'b1;
      terr_d   = 1'b1;
      attn_hit = 1'b1;
    end
    if (abort) begin
      state_d = IDLE;
      ack_d   = 1'b0;
      sts_d   = 1'b0;
      done_d  = 1'b1;
      cnt_d   = '0;
      rx_d    = '0;
      tx_d    = '0;
    end

    if (attn_hit || attn_set) attn_d = 1'b1;
    else if (attn_clr)        attn_d = 1'b0;
    else                      attn_d = attn_q;

    tmo_d = (!timed || req_edge) ? '0
          : tmo_q + 24'd1;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      req_sync  <= '0;
      data_sync <= '0;
      sel_sync  <= '0;
      req_q     <= 1'b0;
      state_q   <= IDLE;
      ack_q     <= 1'b0;
      sts_q     <= 1'b0;
      done_q    <= 1'b1;
      attn_q    <= 1'b0;
      vld_q     <= 1'b0;
      perr_q    <= 1'b0;
      terr_q    <= 1'b0;
      word_q    <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      cnt_q     <= '0;
      tmo_q     <= '0;
    end else begin
      req_sync  <= SYNC_STAGES'({req_sync, esdi_transfer_req});
      data_sync <= SYNC_STAGES'({data_sync, esdi_command_data});
      sel_sync  <= SYNC_STAGES'({sel_sync, esdi_drive_selected});
      req_q     <= req_s;
      state_q   <= state_d;
      ack_q     <= ack_d;
      sts_q     <= sts_d;
      done_q    <= done_d;
      attn_q    <= attn_d;
      vld_q     <= vld_d;
      perr_q    <= perr_d;
      terr_q    <= terr_d;
      word_q    <= word_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
    end
  end

  assign esdi_transfer_ack     = ack_q;
  assign esdi_confstat_data    = sts_q;
  assign esdi_command_complete = done_q;
  assign esdi_attention        = attn_q;
  assign parity_err            = perr_q;
  assign timeout_err           = terr_q;
  assign proc.cmd_valid        = vld_q;
  assign proc.cmd_word         = word_q;
  assign proc.rsp_ready        = (state_q == RSP_WAIT);

endmodule

// File: tb/tb_esdi_cmd_sequencer.sv
// Self-checking bench for esdi_cmd_sequencer: bench acts
// as host and processor, checked against a behavioural model.
module tb_esdi_cmd_sequencer;
  localparam int SYNC = 2;
  localparam int TMO  = 100;

  logic aclk = 1'b0;
  logic aresetn = 1'b1;
  logic esdi_transfer_req = 1'b0;
  logic esdi_command_data = 1'b0;
  logic esdi_drive_selected = 1'b0;
  logic esdi_transfer_ack, esdi_confstat_data;
  logic esdi_command_complete, esdi_attention;
  logic attn_set = 1'b0, attn_clr = 1'b0;
  logic parity_err, timeout_err;

  esdi_cmd_sequencer_if proc_if();

  always #5 aclk = ~aclk;

  esdi_cmd_sequencer #(
    .SYNC_STAGES(SYNC),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .esdi_transfer_req(esdi_transfer_req),
    .esdi_command_data(esdi_command_data),
    .esdi_drive_selected(esdi_drive_selected),
    .esdi_transfer_ack(esdi_transfer_ack),
    .esdi_confstat_data(esdi_confstat_data),
    .esdi_command_complete(esdi_command_complete),
    .esdi_attention(esdi_attention),
    .proc(proc_if),
    .attn_set(attn_set),
    .attn_clr(attn_clr),
    .parity_err(parity_err),
    .timeout_err(timeout_err)
  );

  int errors = 0;
  int checks = 0;

  // model state
  logic [15:0] m_word = '0;
  bit   m_armed = 1'b0;
  int   m_valid = 0, m_perr = 0, m_terr = 0;
  int   d_valid = 0, d_perr = 0, d_terr = 0;
  int   dmax = 0;

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, got, exp);
    end
  endtask

  function automatic bit par_good(input logic [15:0] w);
    return ($countones(w) % 2) == 0;
  endfunction

  function automatic logic [16:0] sts_model(
      input logic [15:0] w);
    return {w, par_good(w)};
  endfunction

  // per-cycle compare against the model
  initial begin
    bit   p_ok = 1'b0;
    logic p_attn = 1'b0, p_set = 1'b0;
    logic p_clr = 1'b0, p_vld = 1'b0;
    logic e_attn;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        p_ok  = 1'b0;
        p_vld = 1'b0;
      end else begin
        if (parity_err)  d_perr++;
        if (timeout_err) d_terr++;
        if (proc_if.cmd_valid && !p_vld) d_valid++;
        if (proc_if.cmd_valid) begin
          chk("mon_cmd_word", proc_if.cmd_word, m_word);
          chk("mon_valid_expected", m_armed, 1);
          chk("mon_complete_exec",
              esdi_command_complete, 0);
        end
        if (p_ok) begin
          if (p_set || parity_err || timeout_err)
            e_attn = 1'b1;
          else if (p_clr)
            e_attn = 1'b0;
          else
            e_attn = p_attn;
          chk("mon_attention", esdi_attention, e_attn);
        end
        p_ok   = 1'b1;
        p_attn = esdi_attention;
        p_set  = attn_set;
        p_clr  = attn_clr;
        p_vld  = proc_if.cmd_valid;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic gap();
    repeat ($urandom_range(0, dmax)) tick();
  endtask

  task automatic wait_ack(input logic lvl,
                          input int lat,
                          input string nm);
    int n = 0;
    while (esdi_transfer_ack !== lvl && n < 40) begin
      tick();
      n++;
    end
    chk(nm, n, lat);
  endtask

  task automatic send_cmd(input logic [15:0] w,
                          input logic p,
                          input int nbits);
    logic [16:0] bits;
    bits = {w, p};
    for (int i = 16; i > 16 - nbits; i--) begin
      esdi_command_data = bits[i];
      esdi_transfer_req = 1'b1;
      wait_ack(1'b1, SYNC + 1, "cmd_ack_rise");
      gap();
      esdi_transfer_req = 1'b0;
      wait_ack(1'b0, SYNC + 1, "cmd_ack_fall");
      gap();
    end
  endtask

  task automatic read_sts(input int nbits,
                          output logic [16:0] got);
    got = '0;
    for (int i = 0; i < nbits; i++) begin
      esdi_transfer_req = 1'b1;
      wait_ack(1'b1, SYNC + 2, "sts_ack_rise");
      got = {got[15:0], esdi_confstat_data};
      gap();
      esdi_transfer_req = 1'b0;
      wait_ack(1'b0, SYNC + 1, "sts_ack_fall");
      gap();
    end
  endtask

  task automatic accept(input int d);
    int n = 0;
    while (!proc_if.cmd_valid && n < 20) begin
      tick();
      n++;
    end
    chk("cmd_valid_seen", proc_if.cmd_valid, 1);
    repeat (d) tick();
    proc_if.cmd_ready = 1'b1;
    tick();
    proc_if.cmd_ready = 1'b0;
    m_armed = 1'b0;
    chk("cmd_valid_drop", proc_if.cmd_valid, 0);
  endtask

  task automatic respond(input logic [15:0] rw);
    int n = 0;
    while (!proc_if.rsp_ready && n < 20) begin
      tick();
      n++;
    end
    chk("rsp_ready_seen", proc_if.rsp_ready, 1);
    proc_if.rsp_word  = rw;
    proc_if.rsp_valid = 1'b1;
    tick();
    proc_if.rsp_valid = 1'b0;
    chk("rsp_ready_drop", proc_if.rsp_ready, 0);
  endtask

  task automatic start_good(input logic [15:0] w);
    m_word  = w;
    m_armed = 1'b1;
    m_valid++;
    send_cmd(w, par_good(w), 17);
    tick();
    chk("valid_count", d_valid, m_valid);
    chk("complete_low", esdi_command_complete, 0);
  endtask

  task automatic do_txn(input logic [15:0] w,
                        input logic [15:0] rw);
    logic [16:0] got;
    start_good(w);
    accept($urandom_range(0, 6));
    respond(rw);
    read_sts(17, got);
    chk("sts_word", got, sts_model(rw));
    chk("complete_high", esdi_command_complete, 1);
    chk("confstat_idle", esdi_confstat_data, 0);
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_ack"}, esdi_transfer_ack, 0);
    chk({nm, "_confstat"}, esdi_confstat_data, 0);
    chk({nm, "_complete"}, esdi_command_complete, 1);
    chk({nm, "_attn"}, esdi_attention, 0);
    chk({nm, "_cmd_valid"}, proc_if.cmd_valid, 0);
    chk({nm, "_cmd_word"}, proc_if.cmd_word, 0);
    chk({nm, "_rsp_ready"}, proc_if.rsp_ready, 0);
    chk({nm, "_perr"}, parity_err, 0);
    chk({nm, "_terr"}, timeout_err, 0);
  endtask

  initial begin
    logic [16:0] got;
    logic        a0;
    int          n;
    logic [15:0] w;
    proc_if.cmd_ready = 1'b0;
    proc_if.rsp_valid = 1'b0;
    proc_if.rsp_word  = '0;
    #1 aresetn = 1'b0;
    #2 chk_reset("rst");
    repeat (3) @(posedge aclk);
    #1;
    esdi_drive_selected = 1'b1;
    aresetn = 1'b1;
    repeat (4) tick();

    // good 0x1234, req ignored while executing
    start_good(16'h1234);
    chk("cmd_word_1234", proc_if.cmd_word, 16'h1234);
    esdi_transfer_req = 1'b1;
    repeat (8) tick();
    chk("no_ack_exec", esdi_transfer_ack, 0);
    esdi_transfer_req = 1'b0;
    repeat (4) tick();
    accept(2);
    respond(16'hA5A5);
    read_sts(17, got);
    chk("sts_a5a5", got, 17'h14B4B);
    chk("a5a5_complete", esdi_command_complete, 1);

    // bad parity
    m_perr++;
    send_cmd(16'h1234, 1'b1, 17);
    tick();
    chk("perr_count", d_perr, m_perr);
    chk("attn_after_perr", esdi_attention, 1);
    chk("complete_after_perr", esdi_command_complete, 1);
    repeat (5) tick();
    chk("no_valid_after_perr", d_valid, m_valid);

    // set beats clear
    attn_set = 1'b1;
    attn_clr = 1'b1;
    tick();
    attn_set = 1'b0;
    attn_clr = 1'b0;
    chk("attn_set_wins", esdi_attention, 1);
    attn_clr = 1'b1;
    tick();
    attn_clr = 1'b0;
    chk("attn_cleared", esdi_attention, 0);

    // host stalls after 5 bits
    send_cmd(16'h1234, 1'b0, 5);
    n = 0;
    while (!timeout_err && n < 300) begin
      tick();
      n++;
    end
    chk("timeout_window",
        (n >= TMO - SYNC) && (n <= TMO + SYNC), 1);
    m_terr++;
    chk("timeout_ack", esdi_transfer_ack, 0);
    chk("timeout_complete", esdi_command_complete, 1);
    chk("timeout_attn", esdi_attention, 1);
    tick();
    chk("timeout_pulse", timeout_err, 0);
    chk("terr_count", d_terr, m_terr);
    attn_clr = 1'b1;
    tick();
    attn_clr = 1'b0;
    do_txn(16'h1234, 16'h0F0F);

    // deselect during status bit 8
    start_good(16'hBEEF);
    accept(1);
    respond(16'hFFFF);
    read_sts(7, got);
    chk("sts_first7", got, 17'h0007F);
    a0 = esdi_attention;
    esdi_transfer_req = 1'b1;
    wait_ack(1'b1, SYNC + 2, "sts8_ack_rise");
    esdi_drive_selected = 1'b0;
    wait_ack(1'b0, SYNC + 1, "desel_abort");
    chk("desel_complete", esdi_command_complete, 1);
    chk("desel_confstat", esdi_confstat_data, 0);
    chk("desel_attn", esdi_attention, a0);
    esdi_transfer_req = 1'b0;
    repeat (4) tick();
    esdi_transfer_req = 1'b1;
    repeat (8) tick();
    chk("no_ack_deselected", esdi_transfer_ack, 0);
    esdi_transfer_req = 1'b0;
    repeat (4) tick();
    esdi_drive_selected = 1'b1;
    repeat (4) tick();
    chk("desel_terr", d_terr, m_terr);

    // reset during command bit 10
    send_cmd(16'h1234, 1'b0, 9);
    esdi_command_data = 1'b0;
    esdi_transfer_req = 1'b1;
    wait_ack(1'b1, SYNC + 1, "bit10_ack_rise");
    aresetn = 1'b0;
    #1 chk_reset("midrst");
    esdi_transfer_req = 1'b0;
    repeat (3) tick();
    aresetn = 1'b1;
    repeat (10) tick();
    chk("midrst_no_valid", d_valid, m_valid);
    chk("midrst_complete", esdi_command_complete, 1);

    // randomized traffic
    dmax = 3;
    for (int t = 0; t < 10; t++) begin
      w = 16'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        do_txn(w, 16'($urandom));
      end else begin
        m_perr++;
        send_cmd(w, !par_good(w), 17);
        tick();
        chk("rnd_perr", d_perr, m_perr);
        chk("rnd_attn", esdi_attention, 1);
        repeat (3) tick();
        chk("rnd_no_valid", d_valid, m_valid);
      end
      if ($urandom_range(0, 1) == 1) attn_set = 1'b1;
      else attn_clr = 1'b1;
      tick();
      attn_set = 1'b0;
      attn_clr = 1'b0;
      tick();
    end

    chk("final_perr", d_perr, m_perr);
    chk("final_terr", d_terr, m_terr);
    chk("final_valid", d_valid, m_valid);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end
endmodule
